// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
// Converts pan/tilt coordinates into hobby-servo PWM frames with per-frame
// slew limiting. It also gates the laser through a frame-counted safety
// timeout with a lockout state.
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES     = 1_000_000,
  parameter int PULSE_MIN         = 50_000,
  parameter int PULSE_SPAN        = 50_000,
  parameter int MAX_STEP          = 500,
  parameter int LASER_MAX_PERIODS = 50,
  localparam int CNT_W            = $clog2(PERIOD_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      driven_coordinates_x,
  input  logic [11:0]      driven_coordinates_y,
  input  logic             fire,
  output logic             pwm_x,
  output logic             pwm_y,
  output logic             laser,
  output logic             laser_lockout,
  output logic             period_start,
  output logic [CNT_W-1:0] pulse_x,
  output logic [CNT_W-1:0] pulse_y
);

  localparam int PROD_W = 12 + CNT_W;
  localparam int TMR_W  = (LASER_MAX_PERIODS < 1) ? 1 : $clog2(LASER_MAX_PERIODS + 1);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] SPAN_C   = CNT_W'(PULSE_SPAN);
  localparam logic [CNT_W-1:0] CENTRE_C = CNT_W'(PULSE_MIN + PULSE_SPAN / 2);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(MAX_STEP);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LASER_MAX_PERIODS - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(LASER_MAX_PERIODS);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ON      = 2'd1,
    ST_LOCKOUT = 2'd2
  } laser_state_t;

  logic [CNT_W-1:0] cnt_reg;
  logic             period_start_reg;
  laser_state_t     state_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             laser_reg;
  logic             lockout_reg;

  // Free-running frame counter and its registered start-of-frame strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= (cnt_reg == LAST_C) ? '0 : cnt_reg + 1'b1;
      period_start_reg <= (cnt_reg == '0);
    end
  end

  // One identical channel per axis: index 0 is pan (x), index 1 is tilt (y)
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    logic [11:0]       coord;
    logic [PROD_W-1:0] product;
    logic [CNT_W-1:0]  target_next;
    logic [CNT_W-1:0]  target_reg;
    logic [CNT_W-1:0]  pulse_reg;
    logic [CNT_W-1:0]  pulse_next;
    logic [CNT_W-1:0]  diff;
    logic              pwm_reg;

    assign coord = (gi == 0) ? driven_coordinates_x : driven_coordinates_y;

    // Linear coordinate-to-width map; the >>12 floors the scaled span
    always_comb begin
      product     = PROD_W'(coord) * PROD_W'(SPAN_C);
      target_next = MIN_C + CNT_W'(product >> 12);
    end

    // Next applied width: step toward the target by at most MAX_STEP
    always_comb begin
      pulse_next = pulse_reg;
      diff       = '0;
      if (MAX_STEP == 0) begin
        pulse_next = target_reg;
      end else if (target_reg > pulse_reg) begin
        diff       = target_reg - pulse_reg;
        pulse_next = pulse_reg + ((diff > STEP_C) ? STEP_C : diff);
      end else if (target_reg < pulse_reg) begin
        diff       = pulse_reg - target_reg;
        pulse_next = pulse_reg - ((diff > STEP_C) ? STEP_C : diff);
      end
    end

    // Target sampled every cycle; width committed only on the last frame
    // cycle so the next frame starts cleanly with the new value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        target_reg <= CENTRE_C;
        pulse_reg  <= CENTRE_C;
        pwm_reg    <= 1'b0;
      end else begin
        target_reg <= target_next;
        if (cnt_reg == LAST_C) begin
          pulse_reg <= pulse_next;
        end
        pwm_reg <= (cnt_reg < pulse_reg);
      end
    end
  end

  // Laser safety FSM: fire drop always wins, timeout counted in frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_OFF;
      timer_reg   <= '0;
      laser_reg   <= 1'b0;
      lockout_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          laser_reg   <= 1'b0;
          lockout_reg <= 1'b0;
          if (fire) begin
            state_reg <= ST_ON;
            timer_reg <= '0;
            laser_reg <= 1'b1;
          end
        end
        ST_ON: begin
          if (!fire) begin
            state_reg <= ST_OFF;
            laser_reg <= 1'b0;
          end else if (period_start_reg) begin
            if (timer_reg == TMR_LAST) begin
              state_reg   <= ST_LOCKOUT;
              timer_reg   <= TMR_MAX;
              laser_reg   <= 1'b0;
              lockout_reg <= 1'b1;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (period_start_reg && !fire) begin
            state_reg   <= ST_OFF;
            timer_reg   <= '0;
            lockout_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_OFF;
          timer_reg   <= '0;
          laser_reg   <= 1'b0;
          lockout_reg <= 1'b0;
        end
      endcase
    end
  end

  assign period_start  = period_start_reg;
  assign pwm_x         = g_axis[0].pwm_reg;
  assign pwm_y         = g_axis[1].pwm_reg;
  assign pulse_x       = g_axis[0].pulse_reg;
  assign pulse_y       = g_axis[1].pulse_reg;
  assign laser         = laser_reg;
  assign laser_lockout = lockout_reg;

endmodule
